// File: rtl/ir_sampler_if.sv
// A2D request/response channel between the IR sampler (master) and the converter (slave).
// a2d_strt is a one-cycle request, a2d_chnl is held until the one-cycle a2d_cnv_cmplt, and a2d_res is valid only with that strobe.
interface ir_sampler_if;
    logic        a2d_strt;
    logic [2:0]  a2d_chnl;
    logic        a2d_cnv_cmplt;
    logic [11:0] a2d_res;

    modport master (
        output a2d_strt,
        output a2d_chnl,
        input  a2d_cnv_cmplt,
        input  a2d_res
    );

    modport slave (
        input  a2d_strt,
        input  a2d_chnl,
        output a2d_cnv_cmplt,
        output a2d_res
    );
endinterface

// File: rtl/ir_sampler.sv
// Periodic IR frame sampler: 8 ambient conversions, emitter settle, 8 lit conversions,
// then an atomic publish of lit-minus-ambient (floored at 0) with a one-cycle IR_vld.
module ir_sampler #(
    parameter int PERIOD_CYCLES  = 50000,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    ir_sampler_if.master a2d,
    output logic         IR_en,
    output logic [11:0]  IR_R0,
    output logic [11:0]  IR_R1,
    output logic [11:0]  IR_R2,
    output logic [11:0]  IR_R3,
    output logic [11:0]  IR_L0,
    output logic [11:0]  IR_L1,
    output logic [11:0]  IR_L2,
    output logic [11:0]  IR_L3,
    output logic         IR_vld,
    output logic         a2d_timeout,
    output logic         frame_ovr,
    output logic [2:0]   state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AMB_REQ  = 3'd1,
        AMB_WAIT = 3'd2,
        SETTLE   = 3'd3,
        LIT_REQ  = 3'd4,
        LIT_WAIT = 3'd5,
        COMMIT   = 3'd6
    } state_t;

    localparam int PW   = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int CMAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] per_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    ch_q, ch_d;
    logic          tick;
    logic          commit;
    logic          abort;
    logic [11:0]   amb_q [8];
    logic [11:0]   lit_q [8];
    logic [11:0]   ir_q  [8];

    // Tick fires in the last cycle of each period; the counter is parked at 0 while disabled.
    assign tick = en && (per_q == PER_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q <= '0;
        end else if (!en || (per_q == PER_LAST)) begin
            per_q <= '0;
        end else begin
            per_q <= per_q + 1'b1;
        end
    end

    // cnt_q is shared: conversion timeout in *_WAIT, emitter settle time in SETTLE.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = '0;
        commit  = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = AMB_REQ;
                    ch_d    = '0;
                end
            end
            AMB_REQ: state_d = AMB_WAIT;
            LIT_REQ: state_d = LIT_WAIT;
            AMB_WAIT, LIT_WAIT: begin
                if (a2d.a2d_cnv_cmplt) begin
                    if (ch_q == 3'd7) begin
                        ch_d    = '0;
                        state_d = (state_q == AMB_WAIT) ? SETTLE : COMMIT;
                    end else begin
                        ch_d    = ch_q + 3'd1;
                        state_d = (state_q == AMB_WAIT) ? AMB_REQ : LIT_REQ;
                    end
                end else if (cnt_q == TO_LAST) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == SET_LAST) begin
                    state_d = LIT_REQ;
                    ch_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!en) begin
            state_d = IDLE;
            ch_d    = '0;
            commit  = 1'b0;
            abort   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            cnt_q       <= '0;
            IR_vld      <= 1'b0;
            a2d_timeout <= 1'b0;
            frame_ovr   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            IR_vld      <= commit;
            a2d_timeout <= abort;
            frame_ovr   <= tick && (state_q != IDLE);
        end
    end

    // Shadow registers only capture inside a wait; published words change only on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                amb_q[i] <= '0;
                lit_q[i] <= '0;
                ir_q[i]  <= '0;
            end
        end else begin
            if (a2d.a2d_cnv_cmplt && en) begin
                if (state_q == AMB_WAIT) amb_q[ch_q] <= a2d.a2d_res;
                if (state_q == LIT_WAIT) lit_q[ch_q] <= a2d.a2d_res;
            end
            if (commit) begin
                for (int i = 0; i < 8; i++) begin
                    ir_q[i] <= (lit_q[i] >= amb_q[i]) ? (lit_q[i] - amb_q[i]) : 12'd0;
                end
            end
        end
    end

    assign a2d.a2d_strt = (state_q == AMB_REQ) || (state_q == LIT_REQ);
    assign a2d.a2d_chnl = ch_q;
    assign IR_en        = (state_q == SETTLE) || (state_q == LIT_REQ) || (state_q == LIT_WAIT);
    assign state_dbg    = state_q;

    assign IR_R0 = ir_q[0];
    assign IR_R1 = ir_q[1];
    assign IR_R2 = ir_q[2];
    assign IR_R3 = ir_q[3];
    assign IR_L0 = ir_q[4];
    assign IR_L1 = ir_q[5];
    assign IR_L2 = ir_q[6];
    assign IR_L3 = ir_q[7];

endmodule

// File: tb/tb_ir_sampler.sv
// Bench for ir_sampler: A2D responder models, frame scoreboard, directed timing scenarios
// on a PERIOD=200 instance plus an overrun-focused PERIOD=30 instance.
module tb_ir_sampler;
    localparam int PER_A     = 200;
    localparam int PER_B     = 30;
    localparam int SET       = 10;
    localparam int TO        = 50;
    localparam int LAT       = 5;
    localparam int CONV_CYC  = 1 + LAT;
    localparam int FRAME_LEN = 16 * CONV_CYC + SET + 1;
    localparam int IR_EN_LEN = SET + 8 * CONV_CYC;
    localparam int OVR_PER_FRAME_B = FRAME_LEN / PER_B;
    localparam int VLD_GAP_B = ((FRAME_LEN + 1 + PER_B - 1) / PER_B) * PER_B;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    always #5 clk = ~clk;

    ir_sampler_if bus_a ();
    ir_sampler_if bus_b ();

    logic        ir_en_a, vld_a, to_a, ovr_a;
    logic [2:0]  st_a;
    logic [11:0] r0, r1, r2, r3, l0, l1, l2, l3;
    logic [95:0] ir_flat;
    assign ir_flat = {l3, l2, l1, l0, r3, r2, r1, r0};

    logic        ir_en_b, vld_b, to_b, ovr_b;
    logic [2:0]  st_b;
    logic [11:0] br0, br1, br2, br3, bl0, bl1, bl2, bl3;

    ir_sampler #(.PERIOD_CYCLES(PER_A), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .a2d(bus_a),
        .IR_en(ir_en_a),
        .IR_R0(r0), .IR_R1(r1), .IR_R2(r2), .IR_R3(r3),
        .IR_L0(l0), .IR_L1(l1), .IR_L2(l2), .IR_L3(l3),
        .IR_vld(vld_a), .a2d_timeout(to_a), .frame_ovr(ovr_a), .state_dbg(st_a)
    );

    ir_sampler #(.PERIOD_CYCLES(PER_B), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .a2d(bus_b),
        .IR_en(ir_en_b),
        .IR_R0(br0), .IR_R1(br1), .IR_R2(br2), .IR_R3(br3),
        .IR_L0(bl0), .IR_L1(bl1), .IR_L2(bl2), .IR_L3(bl3),
        .IR_vld(vld_b), .a2d_timeout(to_b), .frame_ovr(ovr_b), .state_dbg(st_b)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: one expected 8-word frame per completed set of lit conversions.
    logic [95:0] exp_q[$];
    logic [95:0] last_exp = '0;
    logic [11:0] amb_tab [8];
    logic [11:0] lit_tab [8];
    logic [11:0] seen_amb [8];
    logic [11:0] seen_lit [8];
    bit withhold_lit3 = 1'b0;
    bit stray_req = 1'b0;

    // Sensor/A2D model for instance A: emitter state at request time picks lit vs ambient.
    initial begin : a2d_model_a
        int pend;
        logic [2:0] pch;
        bit plit;
        logic [95:0] e;
        pend = 0; pch = '0; plit = 1'b0; e = '0;
        bus_a.a2d_cnv_cmplt = 1'b0;
        bus_a.a2d_res = '0;
        forever begin
            @(posedge clk); #1;
            bus_a.a2d_cnv_cmplt = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0 && !(withhold_lit3 && plit && pch == 3'd3)) begin
                        bus_a.a2d_cnv_cmplt = 1'b1;
                        bus_a.a2d_res = plit ? lit_tab[pch] : amb_tab[pch];
                        if (plit) seen_lit[pch] = bus_a.a2d_res;
                        else      seen_amb[pch] = bus_a.a2d_res;
                        if (plit && pch == 3'd7) begin
                            for (int k = 0; k < 8; k++)
                                e[12*k +: 12] = (seen_lit[k] >= seen_amb[k]) ? seen_lit[k] - seen_amb[k] : 12'd0;
                            exp_q.push_back(e);
                        end
                    end
                end
                if (bus_a.a2d_strt) begin
                    pend = LAT;
                    pch  = bus_a.a2d_chnl;
                    plit = ir_en_a;
                end
                if (stray_req) begin
                    bus_a.a2d_cnv_cmplt = 1'b1;
                    bus_a.a2d_res = 12'hABC;
                    stray_req = 1'b0;
                end
            end
        end
    end

    initial begin : a2d_model_b
        int pend;
        pend = 0;
        bus_b.a2d_cnv_cmplt = 1'b0;
        bus_b.a2d_res = '0;
        forever begin
            @(posedge clk); #1;
            bus_b.a2d_cnv_cmplt = 1'b0;
            if (!rst_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus_b.a2d_cnv_cmplt = 1'b1;
                        bus_b.a2d_res = 12'($urandom_range(0, 4095));
                    end
                end
                if (bus_b.a2d_strt) pend = LAT;
            end
        end
    end

    int vld_cnt = 0, strt_cnt = 0, to_cnt = 0, en_run = 0, last_run = 0;
    bit prev_vld = 1'b0;

    initial begin : mon_a
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                en_run = 0;
                prev_vld = 1'b0;
            end else begin
                if (bus_a.a2d_strt) strt_cnt++;
                if (to_a) to_cnt++;
                if (ir_en_a) en_run++;
                else if (en_run > 0) begin
                    last_run = en_run;
                    en_run = 0;
                end
                if (vld_a) begin
                    vld_cnt++;
                    check("vld_single", prev_vld, 0);
                    check("ir_en_at_vld", ir_en_a, 0);
                    check("ir_en_len", last_run, IR_EN_LEN);
                    check("exp_avail", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        last_exp = exp_q.pop_front();
                        for (int k = 0; k < 8; k++)
                            check($sformatf("ir_word%0d", k), ir_flat[12*k +: 12], last_exp[12*k +: 12]);
                    end
                end
                prev_vld = vld_a;
            end
        end
    end

    int vld_b_cnt = 0, ovr_b_cnt = 0, strt_b_since = 0, cyc = 0, last_vld_b_cyc = -1;

    initial begin : mon_b
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                vld_b_cnt = 0; ovr_b_cnt = 0; strt_b_since = 0; last_vld_b_cyc = -1;
            end else begin
                if (bus_b.a2d_strt) strt_b_since++;
                if (ovr_b) ovr_b_cnt++;
                if (vld_b) begin
                    vld_b_cnt++;
                    check("b_strt_per_frame", strt_b_since, 16);
                    strt_b_since = 0;
                    check("b_ovr_count", ovr_b_cnt, OVR_PER_FRAME_B * vld_b_cnt);
                    if (last_vld_b_cyc >= 0) check("b_vld_gap", cyc - last_vld_b_cyc, VLD_GAP_B);
                    last_vld_b_cyc = cyc;
                end
            end
        end
    end

    task automatic wait_vld(input int budget);
        int v0;
        int n;
        v0 = vld_cnt;
        n = 0;
        while (vld_cnt == v0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("vld_wait", vld_cnt != v0, 1);
    endtask

    initial begin : main
        int n, v0, s0, t0;
        bit seen;
        for (int k = 0; k < 8; k++) begin
            amb_tab[k] = 12'h100;
            lit_tab[k] = 12'h800 + 12'(k);
        end
        repeat (3) @(posedge clk); #1;
        check("rst_ctl", {bus_a.a2d_strt, ir_en_a, vld_a, to_a, ovr_a, bus_a.a2d_chnl}, 0);
        check("rst_ir", ir_flat, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        en_a = 1'b1;
        en_b = 1'b1;

        // Basic frame
        wait_vld(500);
        for (int k = 0; k < 8; k++)
            check($sformatf("basic_w%0d", k), ir_flat[12*k +: 12], 12'h700 + 12'(k));
        check("basic_vld_cnt", vld_cnt, 1);

        // Clamp
        amb_tab[2] = 12'h900; lit_tab[2] = 12'h100;
        amb_tab[5] = 12'hFFF; lit_tab[5] = 12'hFFF;
        wait_vld(500);
        check("clamp_r2", r2, 0);
        check("clamp_l1", l1, 0);
        check("clamp_r0", r0, 12'h700);
        check("clamp_l3", l3, 12'h707);

        // Random frames
        repeat (5) begin
            for (int k = 0; k < 8; k++) begin
                amb_tab[k] = 12'($urandom_range(0, 4095));
                lit_tab[k] = 12'($urandom_range(0, 4095));
            end
            wait_vld(500);
        end
        check("b_frames_seen", vld_b_cnt >= 3, 1);

        // Timeout on lit channel 3
        for (int k = 0; k < 8; k++) begin
            amb_tab[k] = 12'h050;
            lit_tab[k] = 12'h300 + 12'(16 * k);
        end
        wait_vld(500);
        withhold_lit3 = 1'b1;
        v0 = vld_cnt;
        t0 = to_cnt;
        seen = 1'b0;
        for (n = 0; n < 500 && !seen; n++) begin
            @(posedge clk); #1;
            if (bus_a.a2d_strt && ir_en_a && bus_a.a2d_chnl == 3'd3) seen = 1'b1;
        end
        check("to_req_seen", seen, 1);
        n = 0;
        while (n < 200 && !to_a) begin
            @(posedge clk); #1;
            n++;
        end
        check("to_delay", n, TO + 1);
        check("to_ir_en", ir_en_a, 0);
        repeat (2) @(posedge clk); #1;
        check("to_pulse_cnt", to_cnt - t0, 1);
        check("to_no_vld", vld_cnt, v0);
        check("to_hold", ir_flat, last_exp);
        withhold_lit3 = 1'b0;
        wait_vld(500);

        // en drop during SETTLE
        seen = 1'b0;
        for (n = 0; n < 500 && !seen; n++) begin
            @(posedge clk); #1;
            if (ir_en_a) seen = 1'b1;
        end
        check("settle_seen", seen, 1);
        en_a = 1'b0;
        s0 = strt_cnt;
        v0 = vld_cnt;
        @(posedge clk); #1;
        check("endrop_ir_en", ir_en_a, 0);
        repeat (300) @(posedge clk); #1;
        check("endrop_no_strt", strt_cnt, s0);
        check("endrop_no_vld", vld_cnt, v0);
        check("endrop_hold", ir_flat, last_exp);
        en_a = 1'b1;
        n = 0;
        while (n < 400 && !bus_a.a2d_strt) begin
            @(posedge clk); #1;
            n++;
        end
        check("en_restart", n, PER_A);
        wait_vld(500);

        // Reset in LIT_WAIT
        seen = 1'b0;
        for (n = 0; n < 500 && !seen; n++) begin
            @(posedge clk); #1;
            if (bus_a.a2d_strt && ir_en_a && bus_a.a2d_chnl == 3'd4) seen = 1'b1;
        end
        check("lit_req_seen", seen, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_async_ir", ir_flat, 0);
        check("rst_async_ctl", {bus_a.a2d_strt, ir_en_a, vld_a, to_a, bus_a.a2d_chnl}, 0);
        exp_q.delete();
        v0 = vld_cnt;
        s0 = strt_cnt;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        stray_req = 1'b1;
        repeat (20) @(posedge clk); #1;
        check("stray_no_vld", vld_cnt, v0);
        check("stray_no_strt", strt_cnt, s0);
        check("stray_ir", ir_flat, 0);
        check("stray_ir_en", ir_en_a, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
